// File: rtl/ss_scan_driver.sv
// Multiplexed N-digit common-anode 7-segment driver with a double-buffered frame and a ghosting guard.
// Optional macro SS_LZ_BLANK_EN enables leading-zero suppression on the displayed frame.

module ss_seg_dec (
  input  logic [3:0] code_i,
  input  logic       hex_i,
  output logic [6:0] seg_o
);
  // Active-low segments, bit 6 = a ... bit 0 = g.
  always_comb begin
    seg_o = 7'b1111110;
    case (code_i)
      4'd0:  seg_o = 7'b0000001;
      4'd1:  seg_o = 7'b1001111;
      4'd2:  seg_o = 7'b0010010;
      4'd3:  seg_o = 7'b0000110;
      4'd4:  seg_o = 7'b1001100;
      4'd5:  seg_o = 7'b0100100;
      4'd6:  seg_o = 7'b0100000;
      4'd7:  seg_o = 7'b0001111;
      4'd8:  seg_o = 7'b0000000;
      4'd9:  seg_o = 7'b0000100;
      4'd10: seg_o = hex_i ? 7'b0001000 : 7'b1111110;
      4'd11: seg_o = hex_i ? 7'b1100000 : 7'b1111110;
      4'd12: seg_o = hex_i ? 7'b0110001 : 7'b1111110;
      4'd13: seg_o = hex_i ? 7'b1000010 : 7'b1111110;
      4'd14: seg_o = hex_i ? 7'b0110000 : 7'b1111110;
      4'd15: seg_o = hex_i ? 7'b0111000 : 7'b1111110;
      default: seg_o = 7'b1111110;
    endcase
  end
endmodule

module ss_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    hex_mode,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              a_to_g,
  output logic                    dp,
  output logic                    frame_tick
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_BLK = CW'(BLANK_CYCLES);
  localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] code;
    logic [NUM_DIGITS-1:0]      dpm;
    logic [NUM_DIGITS-1:0]      blank;
  } frame_t;

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  frame_t                hold_q, hold_d, disp_q, disp_d, in_f, cur;
  logic                  tick_q, tick_d;
  logic [NUM_DIGITS-1:0] an_q, an_d, lz;
  logic [6:0]            seg_q, seg_d, dec;
  logic                  dp_q, dp_d, dark, guard;

  always_comb begin
    cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
    tick_d = (cnt_q == CNT_MAX) && (idx_q == IDX_MAX);
  end

  // The hold->display copy happens in the frame_tick cycle; a load in that
  // same cycle bypasses straight into the display register.
  always_comb begin
    in_f.code  = digits_in;
    in_f.dpm   = dp_in;
    in_f.blank = blank_in;
    hold_d     = load ? in_f : hold_q;
    disp_d     = tick_q ? hold_d : disp_q;
    // Use the incoming frame on the copy cycle so BLANK_CYCLES = 0 never shows stale data.
    cur        = tick_q ? disp_d : disp_q;
  end

`ifdef SS_LZ_BLANK_EN
  always_comb begin
    logic run;
    lz  = '0;
    run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      run   = run & (cur.code[i] == 4'd0);
      lz[i] = run;
    end
  end
`else
  assign lz = '0;
`endif

  ss_seg_dec u_dec (.code_i(cur.code[idx_q]), .hex_i(hex_mode), .seg_o(dec));

  always_comb begin
    guard = (cnt_q < CNT_BLK);
    dark  = cur.blank[idx_q] | lz[idx_q];
    an_d  = '1;
    seg_d = 7'b1111111;
    dp_d  = 1'b1;
    if (!guard && !dark) begin
      an_d[idx_q] = 1'b0;
      seg_d       = dec;
      dp_d        = ~cur.dpm[idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      hold_q <= '0;
      disp_q <= '0;
      tick_q <= 1'b0;
      an_q   <= '1;
      seg_q  <= 7'b1111111;
      dp_q   <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      hold_q <= hold_d;
      disp_q <= disp_d;
      tick_q <= tick_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign an         = an_q;
  assign a_to_g     = seg_q;
  assign dp         = dp_q;
  assign frame_tick = tick_q;
endmodule

// File: tb/tb_ss_scan_driver.sv
// Bench for ss_scan_driver: cycle model feeds a scoreboard queue, plus per-scenario spot checks.
module tb_ss_scan_driver;
  localparam int ND = 4, RD = 8, BC = 2, FR = ND * RD;

  logic        clk = 0, rst = 1, load = 0, hex_mode = 0;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0, blank_in = '0;
  logic [3:0]  an;
  logic [6:0]  a_to_g;
  logic        dp, frame_tick;

  int tests = 0, fails = 0;

  ss_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .clk(clk), .rst(rst), .load(load), .hex_mode(hex_mode), .digits_in(digits_in),
    .dp_in(dp_in), .blank_in(blank_in), .an(an), .a_to_g(a_to_g), .dp(dp),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] an; logic [6:0] seg; logic dp; logic tick; } exp_t;
  typedef struct packed { logic [15:0] dg; logic [3:0] dpm; logic [3:0] bl; } frm_t;
  exp_t q[$];

  function automatic logic [6:0] seg_of(input logic [3:0] v, input logic hx);
    logic [6:0] t [16];
    t = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
          7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
          7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    if (v >= 4'd10 && !hx) return 7'b1111110;
    return t[v];
  endfunction

  // Reference model: n counts cycles since reset; a frame starts every FR cycles.
  int   n = 0;
  frm_t pend = '0, shown = '0;
  always @(posedge clk) begin
    exp_t e;
    frm_t np, ns;
    int c, d;
    logic [3:0] lz;
    logic run;
    e = '{4'hF, 7'h7F, 1'b1, 1'b0};
    if (rst) begin
      n     <= 0;
      pend  <= '0;
      shown <= '0;
    end else begin
      np = load ? frm_t'({digits_in, dp_in, blank_in}) : pend;
      ns = (n > 0 && n % FR == 0) ? np : shown;
      c  = n % RD;
      d  = (n / RD) % ND;
      lz = '0;
      run = 1'b1;
`ifdef SS_LZ_BLANK_EN
      for (int i = ND - 1; i >= 1; i--) begin
        run   = run & (ns.dg[4*i +: 4] == 4'd0);
        lz[i] = run;
      end
`endif
      e.tick = ((n + 1) % FR == 0);
      if (c >= BC && !ns.bl[d] && !lz[d]) begin
        e.an  = 4'hF & ~(4'b0001 << d);
        e.seg = seg_of(ns.dg[4*d +: 4], hex_mode);
        e.dp  = ~ns.dpm[d];
      end
      pend  <= np;
      shown <= ns;
      n     <= n + 1;
    end
    q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      tests++;
      if ({an, a_to_g, dp, frame_tick} !== {e.an, e.seg, e.dp, e.tick}) begin
        fails++;
        $display("FAIL scoreboard t=%0t an=%b seg=%b dp=%b tick=%b expected an=%b seg=%b dp=%b tick=%b",
                 $time, an, a_to_g, dp, frame_tick, e.an, e.seg, e.dp, e.tick);
      end
    end
  end

  task automatic do_load(input logic [15:0] v, input logic [3:0] dpv, input logic [3:0] blv);
    @(negedge clk);
    load = 1; digits_in = v; dp_in = dpv; blank_in = blv;
    @(negedge clk);
    load = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    tests++;
    if ({an, a_to_g, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset_outputs got %b %b %b %b expected 1111 1111111 1 0", an, a_to_g, dp, frame_tick);
    end
    rst = 0;
  endtask

  task automatic test_decimal();
    int k;
    do_load(16'h1234, 4'h0, 4'h0);
    k = 0;
    while (!frame_tick && k < 2 * FR) begin @(negedge clk); k++; end
    tests++;
    if (!frame_tick) begin fails++; $display("FAIL tick_timeout got 0 expected 1"); end
    repeat (3) @(negedge clk);
    tests++;
    if ({an, a_to_g} !== {4'b1110, 7'b1001100}) begin
      fails++;
      $display("FAIL digit0_4 got an=%b seg=%b expected an=1110 seg=1001100", an, a_to_g);
    end
    repeat (8) @(negedge clk);
    tests++;
    if ({an, a_to_g} !== {4'b1101, 7'b0000110}) begin
      fails++;
      $display("FAIL digit1_3 got an=%b seg=%b expected an=1101 seg=0000110", an, a_to_g);
    end
    repeat (FR) @(negedge clk);
  endtask

  task automatic test_hex();
    hex_mode = 1;
    do_load(16'h00AF, 4'h0, 4'h0);
    repeat (2 * FR) @(negedge clk);
    hex_mode = 0;
    repeat (FR) @(negedge clk);
  endtask

  task automatic test_multi_load();
    do_load(16'h1111, 4'h0, 4'h0);
    do_load(16'h2222, 4'h0, 4'h0);
    do_load(16'h3333, 4'h0, 4'h0);
    repeat (2 * FR) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int k;
    k = 0;
    @(negedge clk);
    while (!frame_tick && k < 2 * FR) begin @(negedge clk); k++; end
    tests++;
    if (!frame_tick) begin fails++; $display("FAIL boundary_timeout got 0 expected 1"); end
    load = 1; digits_in = 16'h5678; dp_in = 4'h0; blank_in = 4'h0;
    @(negedge clk);
    load = 0;
    repeat (2) @(negedge clk);
    tests++;
    if ({an, a_to_g} !== {4'b1110, 7'b0000000}) begin
      fails++;
      $display("FAIL boundary_load got an=%b seg=%b expected an=1110 seg=0000000", an, a_to_g);
    end
    repeat (2 * FR) @(negedge clk);
  endtask

  task automatic test_blank_dp();
    do_load(16'h9876, 4'b0100, 4'b0100);
    repeat (2 * FR) @(negedge clk);
    do_load(16'h4321, 4'b0001, 4'b0000);
    repeat (2 * FR) @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int k;
    k = 0;
    while (!(an === 4'b1011) && k < 2 * FR) begin @(negedge clk); k++; end
    tests++;
    if (an !== 4'b1011) begin fails++; $display("FAIL digit2_wait got an=%b expected 1011", an); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    tests++;
    if ({an, a_to_g} !== {4'hF, 7'h7F}) begin
      fails++;
      $display("FAIL midreset_dark got an=%b seg=%b expected an=1111 seg=1111111", an, a_to_g);
    end
    repeat (3) @(negedge clk);
    tests++;
    if ({an, a_to_g} !== {4'b1110, 7'b0000001}) begin
      fails++;
      $display("FAIL midreset_first got an=%b seg=%b expected an=1110 seg=0000001", an, a_to_g);
    end
    repeat (2 * FR) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_decimal();
    test_hex();
    test_multi_load();
    test_back_to_back();
    test_blank_dp();
    test_mid_reset();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
